// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: memory-stage control bundle, MEM FSM states
// and architectural register constants.
package mips_pkg;

   typedef struct packed {
      logic reg_write;
      logic mem_to_reg;
      logic mem_write;
   } mem_ctrl_t;

   typedef enum logic {
      MEM_IDLE,
      MEM_WAIT
   } fsm_mem_t;

   localparam logic [4:0] REG_RA = 5'd31;

endpackage

// File: rtl/dmem_access_fsm.sv
// Data-memory handshake controller: tracks an outstanding access, counts wait
// cycles, and produces the request, pipeline stall and bus-error pulse.
module dmem_access_fsm
   import mips_pkg::*;
#(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic memop,
   input  logic misaligned,
   input  logic ready,
   output logic req,
   output logic stall,
   output logic bus_err
);

   localparam int CW = $clog2(TIMEOUT);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   fsm_mem_t state, state_next;
   logic [CW-1:0] cnt, cnt_next;
   logic aligned;

   assign aligned = memop & ~misaligned;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= MEM_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // The access that reaches the last wait count unanswered is abandoned in
   // that same cycle, so the stall lifts and the instruction leaves as a bubble.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      req        = 1'b0;
      bus_err    = 1'b0;
      case (state)
         MEM_IDLE: begin
            req     = aligned;
            bus_err = memop & misaligned;
            if (aligned && !ready) begin
               state_next = MEM_WAIT;
               cnt_next   = CW'(1);
            end
         end
         MEM_WAIT: begin
            if (ready) begin
               req        = aligned;
               state_next = MEM_IDLE;
               cnt_next   = '0;
            end else if (cnt == LAST) begin
               bus_err    = 1'b1;
               state_next = MEM_IDLE;
               cnt_next   = '0;
            end else begin
               req      = aligned;
               cnt_next = cnt + CW'(1);
            end
         end
         default: begin
            state_next = MEM_IDLE;
            cnt_next   = '0;
         end
      endcase
      stall = req & ~ready;
   end

endmodule

// File: rtl/memory_stage.sv
// MEM stage of the 5-stage MIPS pipeline: EX/MEM and MEM/WB registers around
// a variable-latency req/ready data-memory port.
module memory_stage
   import mips_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int TIMEOUT = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             RegWriteE,
   input  logic             MemtoRegE,
   input  logic             MemWriteE,
   input  logic [WIDTH-1:0] ALUOutE,
   input  logic [WIDTH-1:0] WriteDataE,
   input  logic [4:0]       WriteRegE,
   input  logic             FlushM,
   output logic             DmemReq,
   output logic             DmemWe,
   output logic [WIDTH-1:0] DmemAddr,
   output logic [WIDTH-1:0] DmemWData,
   input  logic             DmemReady,
   input  logic [WIDTH-1:0] DmemRData,
   output logic             StallM,
   output logic [WIDTH-1:0] ALUOutM,
   output logic [4:0]       WriteRegM,
   output logic             RegWriteM,
   output logic             BusErrM,
   output logic             RegWriteW,
   output logic             MemtoRegW,
   output logic [WIDTH-1:0] ReadDataW,
   output logic [WIDTH-1:0] ALUOutW,
   output logic [4:0]       WriteRegW
);

   mem_ctrl_t        ctrl_m;
   logic [WIDTH-1:0] write_data_m;
   logic             memop;
   logic             misaligned;
   logic             keep_load;

   // A stalled stage holds its instruction even if the hazard unit asks for
   // a flush; the flush only clears control bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_m       <= '0;
         ALUOutM      <= '0;
         write_data_m <= '0;
         WriteRegM    <= '0;
      end else if (!StallM) begin
         ctrl_m       <= FlushM ? mem_ctrl_t'('0)
                                : '{reg_write: RegWriteE, mem_to_reg: MemtoRegE,
                                    mem_write: MemWriteE};
         ALUOutM      <= ALUOutE;
         write_data_m <= WriteDataE;
         WriteRegM    <= WriteRegE;
      end
   end

   assign memop      = ctrl_m.mem_to_reg | ctrl_m.mem_write;
   assign misaligned = |ALUOutM[1:0];
   assign RegWriteM  = ctrl_m.reg_write;
   assign DmemWe     = ctrl_m.mem_write;
   assign DmemAddr   = ALUOutM;
   assign DmemWData  = write_data_m;

   dmem_access_fsm #(
      .TIMEOUT(TIMEOUT)
   ) u_fsm (
      .clk       (clk),
      .rst_n     (rst_n),
      .memop     (memop),
      .misaligned(misaligned),
      .ready     (DmemReady),
      .req       (DmemReq),
      .stall     (StallM),
      .bus_err   (BusErrM)
   );

   assign keep_load = ctrl_m.mem_to_reg & ~BusErrM;

   // An aborted access retires with no register write; stores never write back.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         RegWriteW <= 1'b0;
         MemtoRegW <= 1'b0;
         ReadDataW <= '0;
         ALUOutW   <= '0;
         WriteRegW <= '0;
      end else if (StallM) begin
         RegWriteW <= 1'b0;
         MemtoRegW <= 1'b0;
         ReadDataW <= '0;
         ALUOutW   <= ALUOutM;
         WriteRegW <= WriteRegM;
      end else begin
         RegWriteW <= ctrl_m.reg_write & ~ctrl_m.mem_write & ~BusErrM;
         MemtoRegW <= keep_load;
         ReadDataW <= keep_load ? DmemRData : '0;
         ALUOutW   <= ALUOutM;
         WriteRegW <= WriteRegM;
      end
   end

endmodule
